// File: rtl/shift_mix_pkg.sv
// Shared types and constants for the shift-mix pipeline: the mode encoding
// and the width of the accepted-transaction counter.
package shift_mix_pkg;

    typedef enum logic [1:0] {
        SHIFT     = 2'd0,
        SHIFT_XOR = 2'd1,
        ROTL      = 2'd2,
        RELOAD    = 2'd3
    } mode_e;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/shift_mix_pipe_stage.sv
// One stallable register stage carrying valid, data and parity flag.
// While i_hold is high the stage keeps its contents, bubbles included.
module smp_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hold,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_flag,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_flag
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_flag  <= 1'b0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_data  <= i_data;
            r_flag  <= i_flag;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_flag  = r_flag;

endmodule

// File: rtl/shift_mix_pipe.sv
// Feedback shift-mix unit: each accepted transaction updates the feedback word
// by mode and launches it down a STAGES-deep stallable pipeline with parity.
module shift_mix_pipe
    import shift_mix_pkg::*;
#(
    parameter int          WIDTH  = 8,
    parameter int          STAGES = 2,
    parameter int unsigned SEED   = 77
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_bit,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_flag,
    output logic [COUNT_W-1:0] out_count
);

    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

    logic               w_stall;
    logic               w_accept;
    logic [WIDTH-1:0]   w_fbNext;
    logic [WIDTH-1:0]   r_fb;
    logic [COUNT_W-1:0] r_count;

    logic               w_sv [STAGES+1];
    logic [WIDTH-1:0]   w_sd [STAGES+1];
    logic               w_sf [STAGES+1];

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_fbNext = r_fb;
        case (mode_e'(in_mode))
            SHIFT:     w_fbNext = {in_bit, r_fb[WIDTH-1:1]};
            SHIFT_XOR: w_fbNext = {in_bit, r_fb[WIDTH-1:1]} ^ SEED_W;
            ROTL:      w_fbNext = {r_fb[WIDTH-2:0], r_fb[WIDTH-1]};
            RELOAD:    w_fbNext = SEED_W;
            default:   w_fbNext = r_fb;
        endcase
    end

    // Accept already implies no stall, so fb and the counter hold during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb    <= SEED_W;
            r_count <= '0;
        end else if (w_accept) begin
            r_fb    <= w_fbNext;
            r_count <= r_count + 1'b1;
        end
    end

    assign w_sv[0] = w_accept;
    assign w_sd[0] = w_fbNext;
    assign w_sf[0] = ^w_fbNext;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        smp_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_hold  (w_stall),
            .i_valid (w_sv[g]),
            .i_data  (w_sd[g]),
            .i_flag  (w_sf[g]),
            .o_valid (w_sv[g+1]),
            .o_data  (w_sd[g+1]),
            .o_flag  (w_sf[g+1])
        );
    end

    assign out_valid = w_sv[STAGES];
    assign out_data  = w_sd[STAGES];
    assign out_flag  = w_sf[STAGES];
    assign out_count = r_count;

endmodule

// File: tb/tb_shift_mix_pipe.sv
// Randomised and directed bench for shift_mix_pipe, compared every cycle
// against a behavioural slot model kept in the bench.
module tb_shift_mix_pipe;
    import shift_mix_pkg::*;

    localparam int          WIDTH  = 8;
    localparam int          STAGES = 2;
    localparam int unsigned SEED   = 32'h4D;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_bit = 1'b0;
    logic [1:0]         in_mode = 2'd0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   out_data;
    logic               out_flag;
    logic [COUNT_W-1:0] out_count;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: pipeline slots, feedback word, counter.
    bit         mValid [STAGES];
    bit [7:0]   mData  [STAGES];
    bit [7:0]   mFb;
    bit [15:0]  mCount;

    shift_mix_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    function automatic bit [7:0] mixModel(bit [7:0] fb, int mode, bit b);
        int v;
        v = int'(fb);
        case (mode)
            0: v = (v / 2) + (b ? 128 : 0);
            1: v = ((v / 2) + (b ? 128 : 0)) ^ int'(SEED);
            2: v = ((v * 2) % 256) + (v / 128);
            default: v = int'(SEED);
        endcase
        return 8'(v);
    endfunction

    function automatic bit parityOf(bit [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 1;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge, reset asynchronously like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                mValid[i] = 1'b0;
                mData[i]  = 8'h00;
            end
            mFb    = 8'(SEED);
            mCount = 16'h0000;
        end else if (!(mValid[STAGES-1] && !out_ready)) begin
            for (int i = STAGES-1; i > 0; i--) begin
                mValid[i] = mValid[i-1];
                mData[i]  = mData[i-1];
            end
            mValid[0] = in_valid;
            if (in_valid) begin
                mFb      = mixModel(mFb, int'(in_mode), in_bit);
                mData[0] = mFb;
                mCount   = mCount + 16'd1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("out_valid", 32'(out_valid), 32'(mValid[STAGES-1]));
        if (mValid[STAGES-1]) begin
            checkOutput("out_data", 32'(out_data), 32'(mData[STAGES-1]));
            checkOutput("out_flag", 32'(out_flag), 32'(parityOf(mData[STAGES-1])));
        end
        checkOutput("in_ready", 32'(in_ready), 32'(!(mValid[STAGES-1] && !out_ready)));
        checkOutput("out_count", 32'(out_count), 32'(mCount));
    end

    task automatic applyStimulus(bit v, mode_e m, bit b, bit r);
        @(posedge clk);
        #2;
        in_valid  = v;
        in_mode   = m;
        in_bit    = b;
        out_ready = r;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("rst out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst out_data", 32'(out_data), 32'h00);
        checkOutput("rst out_flag", 32'(out_flag), 32'h0);
        checkOutput("rst out_count", 32'(out_count), 32'h0);
        checkOutput("rst in_ready", 32'(in_ready), 32'h1);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic litCheck(string name, logic [31:0] act, logic [31:0] exp);
        @(negedge clk);
        #1;
        checkOutput(name, act, exp);
    endtask

    initial begin
        #1000000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Fill the pipe, then reset mid-stream.
        applyStimulus(1'b1, SHIFT, 1'b0, 1'b1);
        applyStimulus(1'b1, ROTL, 1'b0, 1'b0);
        applyStimulus(1'b1, SHIFT, 1'b1, 1'b0);
        doReset();

        // SHIFT from reset with in_bit=1.
        applyStimulus(1'b1, SHIFT, 1'b1, 1'b1);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        @(negedge clk); #1;
        checkOutput("lat out_valid early", 32'(out_valid), 32'h0);
        checkOutput("shift count", 32'(out_count), 32'h1);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        @(negedge clk); #1;
        checkOutput("shift out_valid", 32'(out_valid), 32'h1);
        checkOutput("shift data", 32'(out_data), 32'hA6);
        checkOutput("shift flag", 32'(out_flag), 32'h0);

        // SHIFT_XOR from reset with in_bit=0.
        doReset();
        applyStimulus(1'b1, SHIFT_XOR, 1'b0, 1'b1);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        @(negedge clk); #1;
        checkOutput("xor data", 32'(out_data), 32'h6B);
        checkOutput("xor flag", 32'(out_flag), 32'h1);

        // ROTL then RELOAD from reset.
        doReset();
        applyStimulus(1'b1, ROTL, 1'b1, 1'b1);
        applyStimulus(1'b1, RELOAD, 1'b1, 1'b1);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        litCheck("rotl data", 32'(out_data), 32'h9A);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        @(negedge clk); #1;
        checkOutput("reload data", 32'(out_data), 32'h4D);
        checkOutput("reload flag", 32'(out_flag), 32'h0);

        // Back-pressure with four SHIFT words, in_bit=1.
        doReset();
        applyStimulus(1'b1, SHIFT, 1'b1, 1'b1);
        applyStimulus(1'b1, SHIFT, 1'b1, 1'b1);
        applyStimulus(1'b1, SHIFT, 1'b1, 1'b0);
        @(negedge clk); #1;
        checkOutput("bp in_ready", 32'(in_ready), 32'h0);
        checkOutput("bp hold data", 32'(out_data), 32'hA6);
        applyStimulus(1'b1, SHIFT, 1'b1, 1'b0);
        litCheck("bp hold data 2", 32'(out_data), 32'hA6);
        applyStimulus(1'b1, SHIFT, 1'b1, 1'b1);
        litCheck("bp hold data 3", 32'(out_data), 32'hA6);
        applyStimulus(1'b1, SHIFT, 1'b1, 1'b1);
        @(negedge clk); #1;
        checkOutput("bp drain 2", 32'(out_data), 32'hD3);
        checkOutput("bp count 3", 32'(out_count), 32'h3);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        @(negedge clk); #1;
        checkOutput("bp drain 3", 32'(out_data), 32'hE9);
        checkOutput("bp count 4", 32'(out_count), 32'h4);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        litCheck("bp word 4", 32'(out_data), 32'hF4);

        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 3) != 0), mode_e'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            end
        end

        // Counter wrap.
        doReset();
        repeat (65535) applyStimulus(1'b1, SHIFT, 1'($urandom_range(0, 1)), 1'b1);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        litCheck("count max", 32'(out_count), 32'hFFFF);
        applyStimulus(1'b1, ROTL, 1'b0, 1'b1);
        applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);
        litCheck("count wrap", 32'(out_count), 32'h0000);
        repeat (4) applyStimulus(1'b0, SHIFT, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_mix_pipe.md
# shift_mix_pipe

Parametrised feedback shift-mix unit with a valid/ready pipeline. Each accepted input transaction updates an internal WIDTH-bit feedback word, selected by a 2-bit mode, and launches that word down a STAGES-deep stallable pipeline with a registered parity flag. It is the generalised successor of the fixed 8-bit feedback pair in the top netlist: width, seed and depth are configurable, and it adds explicit flow control, mode select, reset and a transaction counter.

## Interface
- WIDTH, 8: feedback/data word width; legal range >= 2.
- STAGES, 2: output pipeline depth; legal range >= 1.
- SEED, 77 (0x4D): reset and reload value of the feedback word; truncated to WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit can accept this cycle.
- in_bit  in  1  serial bit shifted into the MSB (modes 0, 1).
- in_mode  in  2  0 SHIFT, 1 SHIFT_XOR, 2 ROTL, 3 RELOAD.
- out_valid  out  1  out_data/out_flag valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  feedback word snapshot.
- out_flag  out  1  XOR-reduce (odd parity) of out_data.
- out_count  out  16  accepted-transaction count.

## Operation
- Accept = in_valid && in_ready. Stall = out_valid && !out_ready. in_ready = !stall, combinational, no dependence on in_valid.
- On accept, next feedback word fb_n from fb:
  - SHIFT: {in_bit, fb[WIDTH-1:1]}.
  - SHIFT_XOR: {in_bit, fb[WIDTH-1:1]} ^ SEED.
  - ROTL: {fb[WIDTH-2:0], fb[WIDTH-1]}; in_bit ignored.
  - RELOAD: SEED; in_bit ignored.
- fb and stage 0 load fb_n at the accept edge; stage 0's valid bit loads 1. A non-accept, non-stall edge loads valid 0 into stage 0, so bubbles propagate.
- When not stalled, every stage shifts by one, data and valid together. When stalled, all stages, fb and out_count hold. Bubbles are not collapsed during a stall.
- out_data/out_valid are taken from the last stage. out_flag is computed at stage 0 and pipelined alongside the data, so it is never combinational from the output.
- out_count increments by 1 per accept and wraps 0xFFFF -> 0x0000.
- Reset, asynchronous, at any time including mid-stall:
  - fb = SEED.
  - all stage valid bits = 0, stage data = 0.
  - out_valid = 0, out_data = 0, out_flag = 0, out_count = 0.
  - in_ready = 1 (follows from out_valid = 0).
  - In-flight words are discarded.

## Timing
- Latency: a word accepted at edge k has out_valid high in the cycle after edge k+STAGES-1, provided there is no stall. For STAGES=1, it is valid the cycle after acceptance.
- Throughput: 1 word per cycle while out_ready is held high.
- Output handshake: out_data/out_flag stay stable while out_valid && !out_ready.
- Simultaneous accept and output handshake in the same cycle is legal; both take effect at the same edge.
- Back-to-back accepts chain through fb. Each word sees the fb produced by the previous accept, not the reset value.

## Structure
- Shared package shift_mix_pkg holds:
  - mode enum mode_e: SHIFT=0, SHIFT_XOR=1, ROTL=2, RELOAD=3.
  - COUNT_W=16.
- One sub-module, smp_stage: a single stallable register stage carrying valid, data[WIDTH] and flag, with a hold input and asynchronous active-low reset. The top instantiates STAGES copies in a generate loop.
- fb_n mixing logic and the counter live in the top.

## Test plan
(All scenarios use WIDTH=8, STAGES=2, SEED=0x4D.)
- Reset: assert rst_n=0 mid-stream -> out_valid=0, out_data=0x00, out_flag=0, out_count=0, in_ready=1 immediately. After release, the first SHIFT with in_bit=1 yields 0xA6.
- SHIFT from reset, in_bit=1 -> out_data=0xA6, out_flag=0, out_valid 2 edges after accept, out_count=1.
- SHIFT_XOR from reset, in_bit=0 -> out_data=0x6B, out_flag=1.
- ROTL from reset, then RELOAD -> outputs 0x9A (flag 0), then 0x4D (flag 0) on consecutive cycles.
- Back-pressure: stream 4 SHIFT words with in_bit=1, out_ready=0 from the cycle the first word is output-valid:
  - in_ready drops in the same cycle; out_data holds 0xA6.
  - Raising out_ready drains 0xA6, 0xD3, 0xE9 in order; the 4th word is accepted after the stall clears and is output as 0xF4.
- Counter wrap: preload 0xFFFF accepts (or force), one more accept -> out_count=0x0000.
